calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_pkg.sv | 52 +++++
 rtl/calc_sequencer_if.sv | 38 +++
 rtl/calc_imem.sv | 28 ++
 rtl/calc_sequencer.sv | 161 ++++++++++++++++
 tb/tb_calc_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the calculator sequencer: word layout, field positions, FSM states.
// Latency: n/a (types and a combinational decode helper only).
// Backpressure: n/a.
package calc_pkg;

   localparam int WORD_W   = 24;

   localparam int HALT_BIT = 23;
   localparam int WEN_BIT  = 22;
   localparam int RW_MSB   = 21;
   localparam int RW_LSB   = 19;
   localparam int RX_MSB   = 18;
   localparam int RX_LSB   = 16;
   localparam int RY_MSB   = 15;
   localparam int RY_LSB   = 13;
   localparam int SEL_BIT  = 12;
   localparam int CTRL_MSB = 11;
   localparam int CTRL_LSB = 8;
   localparam int DATA_MSB = 7;
   localparam int DATA_LSB = 0;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic       halt;
      logic       wen;
      logic [2:0] rw;
      logic [2:0] rx;
      logic [2:0] ry;
      logic       sel;
      logic [3:0] ctrl;
      logic [7:0] data_in;
   } instr_t;

   // Split a raw instruction word into named fields using the bit positions above.
   function automatic instr_t decode(input logic [WORD_W-1:0] w);
      instr_t d;
      d.halt    = w[HALT_BIT];
      d.wen     = w[WEN_BIT];
      d.rw      = w[RW_MSB:RW_LSB];
      d.rx      = w[RX_MSB:RX_LSB];
      d.ry      = w[RY_MSB:RY_LSB];
      d.sel     = w[SEL_BIT];
      d.ctrl    = w[CTRL_MSB:CTRL_LSB];
      d.data_in = w[DATA_MSB:DATA_LSB];
      return d;
   endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Host-side bundle of the sequencer: program load, run control and calculator-facing fields.
// Latency: n/a (wires only).
// Backpressure: none; the sequencer issues one instruction per cycle unconditionally.
interface calc_sequencer_if #(
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);

   logic                        LdEn;
   logic [AW-1:0]               LdAddr;
   logic [calc_pkg::WORD_W-1:0] LdData;
   logic                        Start;
   logic                        Abort;
   logic                        Carry;

   logic                        WEN;
   logic [2:0]                  RW;
   logic [2:0]                  RX;
   logic [2:0]                  RY;
   logic                        Sel;
   logic [3:0]                  Ctrl;
   logic [7:0]                  DataIn;
   logic                        Busy;
   logic                        Done;
   logic [AW-1:0]               PC;
   logic                        CarryFlag;

   modport master (
      output LdEn, LdAddr, LdData, Start, Abort, Carry,
      input  WEN, RW, RX, RY, Sel, Ctrl, DataIn, Busy, Done, PC, CarryFlag
   );

   modport slave (
      input  LdEn, LdAddr, LdData, Start, Abort, Carry,
      output WEN, RW, RX, RY, Sel, Ctrl, DataIn, Busy, Done, PC, CarryFlag
   );

endinterface

// File: rtl/calc_imem.sv
// Instruction store: synchronous write, asynchronous read, contents survive reset.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none.
module calc_imem
   import calc_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [WORD_W-1:0]          wr_data,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr,
   output logic [WORD_W-1:0]          rd_data
);

   logic [WORD_W-1:0] mem [DEPTH];

   // Store a program word; deliberately no reset so a program survives Rst.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/calc_sequencer.sv
// Steps a stored program into the calculator, one registered instruction per cycle, until HALT/end/Abort.
// Latency: Start edge drives entry 0; each later edge drives the next entry; Done one edge after the last.
// Backpressure: none; no stalls, Abort is the only way to stop a running program early.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic            Clk,
   input  logic            Rst,
   calc_sequencer_if.slave bus
);

   localparam int             AW        = $clog2(DEPTH);
   localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);

   state_t            state_q, state_nxt;
   logic [AW-1:0]     pc_q, pc_nxt;
   logic [AW-1:0]     rd_addr;
   logic [WORD_W-1:0] rd_word;
   instr_t            instr;
   logic              mem_wr;
   logic              issue;

   logic              wen_q, wen_nxt;
   logic [2:0]        rw_q, rw_nxt;
   logic [2:0]        rx_q, rx_nxt;
   logic [2:0]        ry_q, ry_nxt;
   logic              sel_q, sel_nxt;
   logic [3:0]        ctrl_q, ctrl_nxt;
   logic [7:0]        data_q, data_nxt;
   logic              done_q, done_nxt;
   logic              cflag_q, cflag_nxt;
   // Set when the word currently on the outputs is the program's last one (HALT or top entry).
   logic              fin_q, fin_nxt;

   // Start always fetches entry 0; while running, fetch follows the PC.
   assign rd_addr = (state_q == RUN) ? pc_q : '0;

   // Loads are only honoured while idle, and Rst blocks them.
   assign mem_wr = (state_q == IDLE) && bus.LdEn && !Rst;

   calc_imem #(
      .DEPTH (DEPTH)
   ) u_imem (
      .clk     (Clk),
      .wr_en   (mem_wr),
      .wr_addr (bus.LdAddr),
      .wr_data (bus.LdData),
      .rd_addr (rd_addr),
      .rd_data (rd_word)
   );

   assign instr = decode(rd_word);

   // Next-state and next-output decision: Start, Abort, completion, or issue the next word.
   always_comb begin
      state_nxt = state_q;
      pc_nxt    = pc_q;
      wen_nxt   = 1'b0;
      rw_nxt    = rw_q;
      rx_nxt    = rx_q;
      ry_nxt    = ry_q;
      sel_nxt   = sel_q;
      ctrl_nxt  = ctrl_q;
      data_nxt  = data_q;
      done_nxt  = 1'b0;
      fin_nxt   = fin_q;
      issue     = 1'b0;
      cflag_nxt = cflag_q | ((state_q == RUN) & wen_q & bus.Carry);

      unique case (state_q)
         IDLE: begin
            if (bus.Start) begin
               state_nxt = RUN;
               cflag_nxt = 1'b0;
               issue     = 1'b1;
            end
         end
         RUN: begin
            if (bus.Abort) begin
               state_nxt = IDLE;
               fin_nxt   = 1'b0;
            end else if (fin_q) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
               fin_nxt   = 1'b0;
            end else begin
               issue = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // A HALT word still drives its fields but never writes the register file.
      if (issue) begin
         wen_nxt  = instr.wen & ~instr.halt;
         rw_nxt   = instr.rw;
         rx_nxt   = instr.rx;
         ry_nxt   = instr.ry;
         sel_nxt  = instr.sel;
         ctrl_nxt = instr.ctrl;
         data_nxt = instr.data_in;
         pc_nxt   = rd_addr + AW'(1);
         fin_nxt  = instr.halt | (rd_addr == LAST_ADDR);
      end
   end

   // FSM state register.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Registered PC, calculator fields and status flags.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         pc_q    <= '0;
         wen_q   <= 1'b0;
         rw_q    <= '0;
         rx_q    <= '0;
         ry_q    <= '0;
         sel_q   <= 1'b0;
         ctrl_q  <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         cflag_q <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         pc_q    <= pc_nxt;
         wen_q   <= wen_nxt;
         rw_q    <= rw_nxt;
         rx_q    <= rx_nxt;
         ry_q    <= ry_nxt;
         sel_q   <= sel_nxt;
         ctrl_q  <= ctrl_nxt;
         data_q  <= data_nxt;
         done_q  <= done_nxt;
         cflag_q <= cflag_nxt;
         fin_q   <= fin_nxt;
      end
   end

   assign bus.WEN       = wen_q;
   assign bus.RW        = rw_q;
   assign bus.RX        = rx_q;
   assign bus.RY        = ry_q;
   assign bus.Sel       = sel_q;
   assign bus.Ctrl      = ctrl_q;
   assign bus.DataIn    = data_q;
   assign bus.Busy      = (state_q == RUN);
   assign bus.Done      = done_q;
   assign bus.PC        = pc_q;
   assign bus.CarryFlag = cflag_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed scenarios plus randomized programs against a program-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_calc_sequencer;

   localparam int DEPTH = 16;

   logic Clk = 1'b0;
   logic Rst;

   always #5 Clk = ~Clk;

   calc_sequencer_if #(.DEPTH(DEPTH)) bus ();

   calc_sequencer #(.DEPTH(DEPTH)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [23:0] ref_mem [DEPTH];

   // Advance one edge; outputs are then looked at 1 time unit after it.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Build an instruction word from its documented fields.
   function automatic logic [23:0] mk(input bit halt, input bit wen, input int rw, input int rx,
                                      input int ry, input bit sel, input int ctrl, input int data);
      logic [23:0] w;
      w = {halt, wen, 3'(rw), 3'(rx), 3'(ry), sel, 4'(ctrl), 8'(data)};
      return w;
   endfunction

   // Observed output bundle: {WEN, RW,RX,RY,Sel,Ctrl,DataIn, Busy, Done, PC, CarryFlag}.
   function automatic logic [29:0] obs();
      return {bus.WEN, bus.RW, bus.RX, bus.RY, bus.Sel, bus.Ctrl, bus.DataIn,
              bus.Busy, bus.Done, bus.PC, bus.CarryFlag};
   endfunction

   // Expected bundle in the same layout; 'fields' is {RW,RX,RY,Sel,Ctrl,DataIn}.
   function automatic logic [29:0] expv(input bit wen, input logic [21:0] fields, input bit busy,
                                        input bit done, input int pc, input bit cf);
      return {wen, fields, busy, done, 4'(pc), cf};
   endfunction

   task automatic load_entry(input int a, input logic [23:0] d);
      bus.LdEn   = 1'b1;
      bus.LdAddr = 4'(a);
      bus.LdData = d;
      tick();
      bus.LdEn   = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic test_reset();
      logic [29:0] e;
      Rst = 1'b1;
      bus.Start = 1'b1; bus.Abort = 1'b1; bus.Carry = 1'b1;
      bus.LdEn = 1'b1; bus.LdAddr = '0; bus.LdData = 24'hFFFFFF;
      tick();
      tick();
      e = '0;
      n_cmp++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL reset_state: got %h expected %h", obs(), e);
      end
      Rst = 1'b0;
      bus.Start = 1'b0; bus.Abort = 1'b0; bus.Carry = 1'b0; bus.LdEn = 1'b0;
      tick();
      n_cmp++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL reset_release_idle: got %h expected %h", obs(), e);
      end
   endtask

   task automatic test_directed();
      logic [29:0] e [5];
      load_entry(0, mk(0, 1, 1, 0, 0, 0, 0, 8'h05));
      load_entry(1, mk(0, 1, 2, 1, 1, 1, 0, 8'h00));
      load_entry(2, mk(1, 0, 0, 0, 0, 0, 0, 8'h00));
      e[0] = expv(1, {3'd1, 3'd0, 3'd0, 1'b0, 4'd0, 8'h05}, 1, 0, 1, 0);
      e[1] = expv(1, {3'd2, 3'd1, 3'd1, 1'b1, 4'd0, 8'h00}, 1, 0, 2, 0);
      e[2] = expv(0, 22'd0, 1, 0, 3, 0);
      e[3] = expv(0, 22'd0, 0, 1, 3, 0);
      e[4] = expv(0, 22'd0, 0, 0, 3, 0);
      bus.Start = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         bus.Start = 1'b0;
         n_cmp++;
         if (obs() !== e[c]) begin
            n_fail++; $display("FAIL directed_cycle_%0d: got %h expected %h", c + 1, obs(), e[c]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [29:0] e;
      for (int a = 0; a < DEPTH; a++) begin
         load_entry(a, 24'($urandom) & 24'h7FFFFF);
      end
      bus.Start = 1'b1;
      for (int k = 1; k <= DEPTH; k++) begin
         tick();
         bus.Start = 1'b0;
         e = expv(ref_mem[k-1][22], ref_mem[k-1][21:0], 1, 0, k % DEPTH, 0);
         n_cmp++;
         if (obs() !== e) begin
            n_fail++; $display("FAIL wrap_cycle_%0d: got %h expected %h", k, obs(), e);
         end
      end
      tick();
      e = expv(0, ref_mem[DEPTH-1][21:0], 0, 1, 0, 0);
      n_cmp++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL wrap_done: got %h expected %h", obs(), e);
      end
      tick();
      e = expv(0, ref_mem[DEPTH-1][21:0], 0, 0, 0, 0);
      n_cmp++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL wrap_done_one_cycle: got %h expected %h", obs(), e);
      end
   endtask

   task automatic test_abort();
      logic [29:0] e;
      bit          stray;
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      tick();
      tick();
      bus.Abort = 1'b1;
      tick();
      bus.Abort = 1'b0;
      e = expv(0, ref_mem[2][21:0], 0, 0, 3, 0);
      n_cmp++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL abort_to_idle: got %h expected %h", obs(), e);
      end
      stray = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         stray = stray | bus.Done | bus.Busy;
      end
      n_cmp++;
      if (stray !== 1'b0) begin
         n_fail++; $display("FAIL abort_no_done: got %b expected 0", stray);
      end
   endtask

   task automatic test_priority();
      logic [29:0] e;
      bus.Abort = 1'b1;
      tick();
      bus.Abort = 1'b0;
      e = expv(0, ref_mem[2][21:0], 0, 0, 3, 0);
      n_cmp++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL abort_in_idle_ignored: got %h expected %h", obs(), e);
      end
      bus.Start = 1'b1; bus.Abort = 1'b1;
      tick();
      bus.Start = 1'b0; bus.Abort = 1'b0;
      e = expv(ref_mem[0][22], ref_mem[0][21:0], 1, 0, 1, 0);
      n_cmp++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL start_beats_abort: got %h expected %h", obs(), e);
      end
      bus.Abort = 1'b1;
      tick();
      bus.Abort = 1'b0;
      // HALT word with WEN set: output WEN must still be low; Abort on its cycle suppresses Done.
      load_entry(1, mk(1, 1, 7, 7, 7, 1, 15, 8'hFF));
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      tick();
      e = expv(0, ref_mem[1][21:0], 1, 0, 2, 0);
      n_cmp++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL halt_masks_wen: got %h expected %h", obs(), e);
      end
      bus.Abort = 1'b1;
      tick();
      bus.Abort = 1'b0;
      e = expv(0, ref_mem[1][21:0], 0, 0, 2, 0);
      n_cmp++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL abort_beats_halt: got %h expected %h", obs(), e);
      end
      tick();
      n_cmp++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL abort_beats_halt_after: got %h expected %h", obs(), e);
      end
   endtask

   task automatic test_carry();
      logic [29:0] e [7];
      logic [23:0] w0, w1, w2;
      w0 = mk(0, 1, 1, 2, 3, 0, 1, 8'h11);
      w1 = mk(0, 0, 4, 5, 6, 1, 2, 8'h22);
      w2 = mk(0, 1, 7, 0, 1, 0, 3, 8'h33);
      load_entry(0, w0);
      load_entry(1, w1);
      load_entry(2, w2);
      load_entry(3, mk(1, 0, 0, 0, 0, 0, 0, 0));
      e[0] = expv(1, w0[21:0], 1, 0, 1, 0);
      e[1] = expv(0, w1[21:0], 1, 0, 2, 0);
      e[2] = expv(1, w2[21:0], 1, 0, 3, 0);
      e[3] = expv(0, 22'd0, 1, 0, 4, 1);
      e[4] = expv(0, 22'd0, 0, 1, 4, 1);
      e[5] = expv(0, 22'd0, 0, 0, 4, 1);
      e[6] = expv(1, w0[21:0], 1, 0, 1, 0);
      bus.Start = 1'b1;
      for (int c = 0; c < 7; c++) begin
         tick();
         // Carry is high only across the WEN=0 word and then the WEN=1 word.
         bus.Carry = (c == 1 || c == 2);
         bus.Start = (c == 5);
         n_cmp++;
         if (obs() !== e[c]) begin
            n_fail++; $display("FAIL carry_step_%0d: got %h expected %h", c, obs(), e[c]);
         end
      end
      bus.Abort = 1'b1;
      tick();
      bus.Abort = 1'b0;
   endtask

   task automatic test_rst_mid();
      logic [29:0] e;
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      tick();
      Rst = 1'b1; bus.Start = 1'b1; bus.Abort = 1'b1; bus.Carry = 1'b1;
      bus.LdEn = 1'b1; bus.LdAddr = 4'd0; bus.LdData = 24'h0F0F0F;
      tick();
      Rst = 1'b0; bus.Start = 1'b0; bus.Abort = 1'b0; bus.Carry = 1'b0; bus.LdEn = 1'b0;
      e = '0;
      n_cmp++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL rst_mid_program: got %h expected %h", obs(), e);
      end
      tick();
      n_cmp++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL rst_no_done: got %h expected %h", obs(), e);
      end
      // Reset in IDLE together with a load: the load must be dropped.
      Rst = 1'b1; bus.LdEn = 1'b1; bus.LdAddr = 4'd2; bus.LdData = 24'h0F0F0F;
      tick();
      Rst = 1'b0; bus.LdEn = 1'b0;
      bus.Start = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         bus.Start = 1'b0;
         bus.LdEn  = 1'b0;
         if (k <= 4) e = expv(ref_mem[k-1][22] & ~ref_mem[k-1][23], ref_mem[k-1][21:0], 1, 0, k, 0);
         else        e = expv(0, ref_mem[3][21:0], 0, 1, 4, 0);
         n_cmp++;
         if (obs() !== e) begin
            n_fail++; $display("FAIL replay_cycle_%0d: got %h expected %h", k, obs(), e);
         end
         if (k == 1) begin
            bus.LdEn = 1'b1; bus.LdAddr = 4'd1; bus.LdData = 24'h5A5A5A;
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 20; it++) begin
         int          hpos;
         int          len;
         logic [23:0] w;
         hpos = $urandom_range(0, 21);
         for (int a = 0; a < DEPTH; a++) begin
            w     = 24'($urandom);
            w[23] = (a == hpos);
            load_entry(a, w);
         end
         // Number of words shown before completion: up to and including the HALT, else all entries.
         len = (hpos < DEPTH) ? hpos + 1 : DEPTH;
         for (int pass = 0; pass < 2; pass++) begin
            int          abort_at;
            int          pc;
            bit          aborted, prev_busy, prev_wen, prev_carry, cf, busy, done, wen;
            logic [21:0] hold;
            logic [29:0] e;
            abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len)) : 0;
            aborted = 0; prev_busy = 0; prev_wen = 0; prev_carry = 0; cf = 0;
            busy = 0; done = 0; wen = 0; hold = '0; pc = 0;
            bus.Start = 1'b1;
            for (int k = 1; k <= len + 2; k++) begin
               tick();
               bus.Start = 1'b0; bus.LdEn = 1'b0; bus.Abort = 1'b0;
               cf = cf | (prev_busy & prev_wen & prev_carry);
               if (aborted) begin
                  busy = 0; done = 0; wen = 0;
               end else if (k <= len) begin
                  busy = 1; done = 0;
                  wen  = ref_mem[k-1][22] & ~ref_mem[k-1][23];
                  hold = ref_mem[k-1][21:0];
                  pc   = k % DEPTH;
               end else if (k == len + 1) begin
                  busy = 0; done = 1; wen = 0;
               end else begin
                  busy = 0; done = 0; wen = 0;
               end
               e = expv(wen, hold, busy, done, pc, cf);
               n_cmp++;
               if (obs() !== e) begin
                  n_fail++;
                  $display("FAIL random_it%0d_pass%0d_cycle%0d: got %h expected %h", it, pass, k, obs(), e);
               end
               if (aborted) break;
               prev_busy  = busy;
               prev_wen   = wen;
               prev_carry = 1'($urandom_range(0, 1));
               bus.Carry  = prev_carry;
               if (k <= len) begin
                  if (k == abort_at) begin
                     bus.Abort = 1'b1;
                     aborted   = 1;
                  end
                  bus.Start = ($urandom_range(0, 3) == 0);
                  if ($urandom_range(0, 3) == 0) begin
                     bus.LdEn   = 1'b1;
                     bus.LdAddr = 4'($urandom_range(0, DEPTH - 1));
                     bus.LdData = 24'($urandom);
                  end
               end
            end
            bus.Carry = 1'b0; bus.Start = 1'b0; bus.Abort = 1'b0; bus.LdEn = 1'b0;
            tick();
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst        = 1'b1;
      bus.LdEn   = 1'b0;
      bus.LdAddr = '0;
      bus.LdData = '0;
      bus.Start  = 1'b0;
      bus.Abort  = 1'b0;
      bus.Carry  = 1'b0;
      test_reset();
      test_directed();
      test_wrap();
      test_abort();
      test_priority();
      test_carry();
      test_rst_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
